// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline hold/bubble/flush sequencer for the 5-stage core
// Load-use and no-forward RAW stalls, taken-branch flushes, multi-cycle EXE holds, stall counter.
module hazard_sequencer #(
   parameter int ADDR_W     = 5,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src1_ID,
   input  logic [ADDR_W-1:0] src2_ID,
   input  logic              two_src_ID,
   input  logic [ADDR_W-1:0] dest_EXE,
   input  logic [ADDR_W-1:0] dest_MEM,
   input  logic              WB_EN_EXE,
   input  logic              WB_EN_MEM,
   input  logic              MEM_R_EN_EXE,
   input  logic              forward_EN,
   input  logic              mul_EXE,
   input  logic              branch_taken_EXE,
   output logic              hold_pc,
   output logic              hold_ifid,
   output logic              hold_idex,
   output logic              bubble_idex,
   output logic              bubble_exmem,
   output logic              flush_ifid,
   output logic              mul_busy,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic {IDLE, MUL} state_t;

   localparam bit       MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic [3:0] MUL_LOAD = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       match_exe, match_mem, raw, mul_hold;

   // Register 0 is hard-wired, so it never creates a dependency.
   assign match_exe = (dest_EXE != '0) &&
                      ((src1_ID == dest_EXE) || (two_src_ID && (src2_ID == dest_EXE)));
   assign match_mem = (dest_MEM != '0) &&
                      ((src1_ID == dest_MEM) || (two_src_ID && (src2_ID == dest_MEM)));

   assign raw = (MEM_R_EN_EXE && match_exe) ||
                (!forward_EN && ((WB_EN_EXE && match_exe) || (WB_EN_MEM && match_mem)));

   assign mul_hold = ((state == IDLE) && mul_EXE && MUL_MULTI) ||
                     ((state == MUL) && (cnt != 4'd0));

   assign mul_busy = (state == MUL);

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      hold_pc      = 1'b0;
      hold_ifid    = 1'b0;
      hold_idex    = 1'b0;
      bubble_idex  = 1'b0;
      bubble_exmem = 1'b0;
      flush_ifid   = 1'b0;
      // Outputs stay quiet while reset is held; the pipeline resets on its own.
      if (rst) begin
         if (mul_hold) begin
            hold_pc      = 1'b1;
            hold_ifid    = 1'b1;
            hold_idex    = 1'b1;
            bubble_exmem = 1'b1;
            if (state == IDLE) begin
               state_nxt = MUL;
               cnt_nxt   = MUL_LOAD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end else begin
            if (state == MUL) begin
               state_nxt = IDLE;
            end
            // A squashed ID instruction cannot cause a stall, so flush wins.
            if (branch_taken_EXE) begin
               flush_ifid  = 1'b1;
               bubble_idex = 1'b1;
            end else if (raw) begin
               hold_pc     = 1'b1;
               hold_ifid   = 1'b1;
               bubble_idex = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (hold_pc && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

   localparam int ADDR_W = 5;
   localparam int MC     = 4;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk, rst;
   logic [ADDR_W-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
   logic two_src_ID, WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE, forward_EN, mul_EXE, branch_taken_EXE;
   logic hold_pc, hold_ifid, hold_idex, bubble_idex, bubble_exmem, flush_ifid, mul_busy;
   logic [CNT_W-1:0] stall_cycles;

   hazard_sequencer #(.ADDR_W(ADDR_W), .MUL_CYCLES(MC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
      .dest_EXE(dest_EXE), .dest_MEM(dest_MEM),
      .WB_EN_EXE(WB_EN_EXE), .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_EXE(MEM_R_EN_EXE),
      .forward_EN(forward_EN), .mul_EXE(mul_EXE), .branch_taken_EXE(branch_taken_EXE),
      .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
      .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
      .mul_busy(mul_busy), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic hold_pc, hold_ifid, hold_idex, bubble_idex, bubble_exmem, flush_ifid, mul_busy;
   } exp_t;

   typedef struct {
      logic [ADDR_W-1:0] s1, s2, de, dm;
      logic two, we, wm, mr, fw, br;
      logic e_hold, e_bub, e_flush;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int occ_left = 0;
   int cnt_m = 0;
   exp_t cur_e;
   vec_t tv[11];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // A producer hazards if it is a load in EXE, or any writer when forwarding is off.
   function automatic bit raw_ref();
      logic [ADDR_W-1:0] pd[2];
      bit pa[2];
      bit r = 0;
      pd[0] = dest_EXE; pa[0] = MEM_R_EN_EXE || (!forward_EN && WB_EN_EXE);
      pd[1] = dest_MEM; pa[1] = !forward_EN && WB_EN_MEM;
      for (int p = 0; p < 2; p++) begin
         if (pa[p] && pd[p] != 0) begin
            if (src1_ID == pd[p]) r = 1;
            if (two_src_ID && src2_ID == pd[p]) r = 1;
         end
      end
      return r;
   endfunction

   function automatic bit mul_start();
      return occ_left == 0 && mul_EXE && MC > 1;
   endfunction

   function automatic exp_t model_eval();
      exp_t e = '0;
      if (occ_left > 1 || mul_start()) begin
         e.hold_pc = 1; e.hold_ifid = 1; e.hold_idex = 1; e.bubble_exmem = 1;
      end else if (branch_taken_EXE) begin
         e.flush_ifid = 1; e.bubble_idex = 1;
      end else if (raw_ref()) begin
         e.hold_pc = 1; e.hold_ifid = 1; e.bubble_idex = 1;
      end
      e.mul_busy = occ_left > 0;
      return e;
   endfunction

   task automatic sample_chk();
      cur_e = model_eval();
      #3;
      chk("hold_pc", int'(hold_pc), int'(cur_e.hold_pc));
      chk("hold_ifid", int'(hold_ifid), int'(cur_e.hold_ifid));
      chk("hold_idex", int'(hold_idex), int'(cur_e.hold_idex));
      chk("bubble_idex", int'(bubble_idex), int'(cur_e.bubble_idex));
      chk("bubble_exmem", int'(bubble_exmem), int'(cur_e.bubble_exmem));
      chk("flush_ifid", int'(flush_ifid), int'(cur_e.flush_ifid));
      chk("mul_busy", int'(mul_busy), int'(cur_e.mul_busy));
      chk("stall_cycles", int'(stall_cycles), cnt_m);
   endtask

   task automatic advance();
      bit start = mul_start();
      @(posedge clk);
      #1;
      if (cur_e.hold_pc && cnt_m < CNT_MAX) cnt_m++;
      if (occ_left > 0) occ_left--;
      else if (start) occ_left = MC - 1;
   endtask

   task automatic cycle();
      sample_chk();
      advance();
   endtask

   task automatic clear_inputs();
      src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
      two_src_ID = 0; WB_EN_EXE = 0; WB_EN_MEM = 0; MEM_R_EN_EXE = 0;
      forward_EN = 1; mul_EXE = 0; branch_taken_EXE = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 0;
      @(posedge clk);
      #1;
      rst = 1;
      occ_left = 0;
      cnt_m = 0;
   endtask

   initial begin
      rst = 0;
      clear_inputs();
      #12;
      chk("reset_hold_pc", int'(hold_pc), 0);
      chk("reset_mul_busy", int'(mul_busy), 0);
      chk("reset_stall_cycles", int'(stall_cycles), 0);
      @(posedge clk);
      #1;
      rst = 1;

      // s1 s2 de dm two we wm mr fw br | hold bubble flush
      tv[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[1]  = '{5'd3, 5'd0, 5'd3, 5'd0, 0, 1, 0, 1, 1, 0, 1, 1, 0};
      tv[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
      tv[3]  = '{5'd1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
      tv[4]  = '{5'd1, 5'd5, 5'd5, 5'd0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
      tv[5]  = '{5'd1, 5'd7, 5'd7, 5'd0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
      tv[6]  = '{5'd1, 5'd7, 5'd7, 5'd0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
      tv[7]  = '{5'd9, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 0, 0, 1, 1, 0};
      tv[8]  = '{5'd3, 5'd0, 5'd3, 5'd0, 0, 1, 0, 1, 1, 1, 0, 1, 1};
      tv[9]  = '{5'd7, 5'd0, 5'd7, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tv[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < 11; i++) begin
         src1_ID = tv[i].s1; src2_ID = tv[i].s2; dest_EXE = tv[i].de; dest_MEM = tv[i].dm;
         two_src_ID = tv[i].two; WB_EN_EXE = tv[i].we; WB_EN_MEM = tv[i].wm;
         MEM_R_EN_EXE = tv[i].mr; forward_EN = tv[i].fw; branch_taken_EXE = tv[i].br;
         mul_EXE = 0;
         sample_chk();
         chk($sformatf("vec%0d_hold_pc", i), int'(hold_pc), int'(tv[i].e_hold));
         chk($sformatf("vec%0d_bubble_idex", i), int'(bubble_idex), int'(tv[i].e_bub));
         chk($sformatf("vec%0d_flush_ifid", i), int'(flush_ifid), int'(tv[i].e_flush));
         advance();
      end

      // Load-use: one stall, then the load sits in MEM and forwarding covers it.
      do_reset();
      src1_ID = 3; dest_EXE = 3; WB_EN_EXE = 1; MEM_R_EN_EXE = 1;
      cycle();
      clear_inputs();
      src1_ID = 3; dest_MEM = 3; WB_EN_MEM = 1;
      sample_chk();
      chk("loaduse_release_hold", int'(hold_pc), 0);
      chk("loaduse_count", int'(stall_cycles), 1);
      advance();

      // No forwarding: EXE match then MEM match, then release.
      do_reset();
      forward_EN = 0; two_src_ID = 1; src2_ID = 7; dest_EXE = 7; WB_EN_EXE = 1;
      cycle();
      dest_EXE = 0; WB_EN_EXE = 0; dest_MEM = 7; WB_EN_MEM = 1;
      cycle();
      dest_MEM = 0; WB_EN_MEM = 0;
      sample_chk();
      chk("nofwd_release_hold", int'(hold_pc), 0);
      chk("nofwd_count", int'(stall_cycles), 2);
      advance();

      // Multiplier: three hold cycles, busy from cycle 2, branch in cycle 2 ignored.
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         mul_EXE = (c == 1);
         branch_taken_EXE = (c == 2);
         sample_chk();
         chk($sformatf("mul_c%0d_hold_pc", c), int'(hold_pc), int'(c <= 3));
         chk($sformatf("mul_c%0d_busy", c), int'(mul_busy), int'(c >= 2));
         chk($sformatf("mul_c%0d_flush", c), int'(flush_ifid), 0);
         advance();
      end
      clear_inputs();
      cycle();

      // Reset in the middle of a multi-cycle op takes effect without a clock edge.
      do_reset();
      mul_EXE = 1;
      cycle();
      mul_EXE = 0;
      cycle();
      src1_ID = 3; dest_EXE = 3; MEM_R_EN_EXE = 1;
      #1;
      rst = 0;
      #1;
      chk("rstmid_hold_pc", int'(hold_pc), 0);
      chk("rstmid_hold_idex", int'(hold_idex), 0);
      chk("rstmid_bubble_idex", int'(bubble_idex), 0);
      chk("rstmid_mul_busy", int'(mul_busy), 0);
      chk("rstmid_stall_cycles", int'(stall_cycles), 0);
      @(posedge clk);
      #1;
      chk("rstheld_hold_pc", int'(hold_pc), 0);
      rst = 1;
      occ_left = 0;
      cnt_m = 0;
      clear_inputs();
      cycle();

      // Saturation: a persistent hazard for 20 cycles.
      do_reset();
      src1_ID = 4; dest_EXE = 4; MEM_R_EN_EXE = 1;
      for (int c = 0; c < 20; c++) cycle();
      #3;
      chk("sat_count", int'(stall_cycles), CNT_MAX);
      @(posedge clk);
      #1;

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) do_reset();
         src1_ID = ADDR_W'($urandom_range(0, 3));
         src2_ID = ADDR_W'($urandom_range(0, 3));
         dest_EXE = ADDR_W'($urandom_range(0, 3));
         dest_MEM = ADDR_W'($urandom_range(0, 3));
         two_src_ID = 1'($urandom_range(0, 1));
         WB_EN_EXE = 1'($urandom_range(0, 1));
         WB_EN_MEM = 1'($urandom_range(0, 1));
         MEM_R_EN_EXE = ($urandom_range(0, 3) == 0);
         forward_EN = ($urandom_range(0, 2) != 0);
         mul_EXE = ($urandom_range(0, 7) == 0);
         branch_taken_EXE = ($urandom_range(0, 5) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
